pcie_egress_drain: RTL

//  Downstream consumer of the transaction-layer master's destination FIFOs D0/D1.
//  - Pops both FIFOs under a round-robin arbiter and captures their 6-bit words
//    ({VC, dest, data[3:0]}) into a 2-entry skid buffer.
//  - Presents the words as one valid/ready egress stream tagged with the source

---
 rtl/pcie_egress_drain.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_egress_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcie_egress_drain                                            |
// | Description : Drains the two transaction-layer destination FIFOs (D0/D1)   |
// |               with a round-robin arbiter. Words go into a 2-entry skid     |
// |               buffer and leave on one valid/ready egress stream tagged     |
// |               with their source FIFO. Optional per-source delivery         |
// |               counters.                                                    |
// | Options     : EGRESS_STATS_EN - when defined, cnt_D0/cnt_D1 count the      |
// |               delivered words; when undefined both are tied to zero.       |
// | Ports       : clk, reset (sync, active-high), init (flush pulse)           |
// |               empty_D0/1, data_out0/1   - FIFO status and read data        |
// |               pop_D0/1                  - registered FIFO pop requests     |
// |               egress_data/src/valid/ready - egress stream                  |
// |               idle_out, active_out      - FSM state flags                  |
// |               cnt_D0, cnt_D1            - delivered-word counters          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcie_egress_drain #(
    parameter int DW    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             empty_D0,
    input  logic             empty_D1,
    input  logic [DW-1:0]    data_out0,
    input  logic [DW-1:0]    data_out1,
    output logic             pop_D0,
    output logic             pop_D1,
    output logic [DW-1:0]    egress_data,
    output logic             egress_src,
    output logic             egress_valid,
    input  logic             egress_ready,
    output logic             idle_out,
    output logic             active_out,
    output logic [CNT_W-1:0] cnt_D0,
    output logic [CNT_W-1:0] cnt_D1
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        idle_q, idle_d;
    logic        active_q, active_d;
    logic        pop0_q, pop0_d;
    logic        pop1_q, pop1_d;
    logic        cap_q, cap_d;           // read data is on data_outX this cycle
    logic        cap_src_q, cap_src_d;   // which FIFO that data belongs to
    logic        inflight_q, inflight_d; // a read is issued but not yet written
    logic        rr_last_q, rr_last_d;
    logic [DW:0] ent0_q, ent0_d;         // buffer entries hold {src, word}
    logic [DW:0] ent1_q, ent1_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  occ_q, occ_d;

    logic        w_deq;
    logic [2:0]  w_need;
    logic        w_room;
    logic        w_can_pop;
    logic        w_grant0;
    logic        w_grant1;
    logic [DW:0] w_head;
    logic [DW:0] w_cap_word;

    assign w_head     = head_q ? ent1_q : ent0_q;
    assign w_deq      = (occ_q != 2'd0) && egress_ready;
    assign w_need     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_deq};
    assign w_room     = (w_need < 3'd2);
    // The inflight flag is a single bit, so no new grant while a pop is on the
    // bus: the pop cycle and the capture cycle would otherwise both be
    // outstanding. Grants are allowed again in the capture cycle.
    assign w_can_pop  = (state_q == ST_ACTIVE) && !pop0_q && !pop1_q && w_room;
    assign w_grant0   = w_can_pop && !empty_D0 && (empty_D1 || rr_last_q);
    assign w_grant1   = w_can_pop && !empty_D1 && (empty_D0 || !rr_last_q);
    assign w_cap_word = cap_src_q ? {1'b1, data_out1} : {1'b0, data_out0};

    always_comb begin
        state_d    = state_q;
        pop0_d     = 1'b0;
        pop1_d     = 1'b0;
        cap_d      = pop0_q | pop1_q;
        cap_src_d  = pop1_q;
        inflight_d = inflight_q;
        rr_last_d  = rr_last_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (cap_q) begin
            if (tail_q) begin
                ent1_d = w_cap_word;
            end else begin
                ent0_d = w_cap_word;
            end
            tail_d     = ~tail_q;
            inflight_d = 1'b0;
        end
        if (w_deq) begin
            head_d = ~head_q;
        end
        occ_d = occ_q + {1'b0, cap_q} - {1'b0, w_deq};

        if (w_grant0 || w_grant1) begin
            pop0_d     = w_grant0;
            pop1_d     = w_grant1;
            inflight_d = 1'b1;
            rr_last_d  = w_grant1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty_D0 || !empty_D1 || (occ_q != 2'd0)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (empty_D0 && empty_D1 && (occ_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush: drop buffered words, the returning read and any pending pop.
        if (init) begin
            state_d    = ST_IDLE;
            pop0_d     = 1'b0;
            pop1_d     = 1'b0;
            cap_d      = 1'b0;
            cap_src_d  = 1'b0;
            inflight_d = 1'b0;
            ent0_d     = '0;
            ent1_d     = '0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
            occ_d      = 2'd0;
        end

        idle_d   = (state_d == ST_IDLE);
        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idle_q     <= 1'b1;
            active_q   <= 1'b0;
            pop0_q     <= 1'b0;
            pop1_q     <= 1'b0;
            cap_q      <= 1'b0;
            cap_src_q  <= 1'b0;
            inflight_q <= 1'b0;
            rr_last_q  <= 1'b1;  // D0 wins the first tie
            ent0_q     <= '0;
            ent1_q     <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
            pop0_q     <= pop0_d;
            pop1_q     <= pop1_d;
            cap_q      <= cap_d;
            cap_src_q  <= cap_src_d;
            inflight_q <= inflight_d;
            rr_last_q  <= rr_last_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
        end
    end

    assign pop_D0       = pop0_q;
    assign pop_D1       = pop1_q;
    assign egress_data  = w_head[DW-1:0];
    assign egress_src   = w_head[DW];
    assign egress_valid = (occ_q != 2'd0);
    assign idle_out     = idle_q;
    assign active_out   = active_q;

`ifdef EGRESS_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (init) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (w_deq) begin
            if (w_head[DW]) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt_D0 = cnt0_q;
    assign cnt_D1 = cnt1_q;
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif

endmodule
`default_nettype wire
